uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART `receiver`. It watches the receiver's `rdy` level, captures `data` once per completed frame on the rising edge of `rdy`, and queues bytes in a small synchronous FIFO. It presents a first-word-fall-through read port to the host logic. Overrun is flagged sticky, so software-side logic can detect dropped bytes.

---
 rtl/uart_rx_fifo.sv | 67 ++++++
 tb/tb_uart_rx_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures one byte per rising
// edge of rdy and exposes a first-word-fall-through read port with sticky overrun.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_rdy,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rdy_q;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // Read handshake: rd_data is valid whenever empty is low; an entry is consumed
  // at the clock edge where rd_en is high and empty is low. rd_en on empty is ignored.
  assign push    = rx_rdy & ~rdy_q;
  assign pop     = rd_en & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // rdy_q resets high so a rdy level already present at reset release is not a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rdy_q <= rx_rdy;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count and pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus pushes expected bytes into a queue and a
// negedge monitor checks every accepted pop against it.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             rx_rdy;
  logic [WIDTH-1:0] rx_data;
  logic             rd_en;
  logic             clr_ovf;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [3:0]       count;
  logic             overflow;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: every accepted pop must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got %0h, expected no data", rd_data);
      end else begin
        check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [WIDTH-1:0] b, input int hold);
    rx_data = b;
    rx_rdy  = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    repeat (hold) tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_count", count, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_overflow", overflow, 0);

    // single capture with rdy held high for 10 cycles
    rx_data = 8'hE0;
    rx_rdy  = 1'b1;
    exp_q.push_back(8'hE0);
    tick();
    check("single_count_first", count, 1);
    check("single_rd_data", rd_data, 8'hE0);
    repeat (9) tick();
    check("single_count_held", count, 1);
    rx_rdy = 1'b0;
    tick();
    pop_n(1);
    check("single_empty_after_pop", empty, 1);
    check("single_rd_data_zero", rd_data, 0);

    // ordering and pointer wrap
    for (int i = 1; i <= 5; i++) send_byte(WIDTH'(i), 2);
    pop_n(3);
    check("wrap_count_2", count, 2);
    for (int i = 6; i <= 11; i++) send_byte(WIDTH'(i), 2);
    check("wrap_full", full, 1);
    check("wrap_count_8", count, 8);
    pop_n(8);
    check("wrap_empty", empty, 1);

    // overflow and clear
    for (int i = 0; i < 8; i++) send_byte(8'h10 + WIDTH'(i), 1);
    check("ovf_pre_overflow", overflow, 0);
    send_byte(8'hAA, 3);
    check("ovf_overflow_set", overflow, 1);
    check("ovf_count", count, 8);
    check("ovf_exp_depth", exp_q.size(), 8);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    pop_n(8);
    check("ovf_drained_empty", empty, 1);

    // push and pop together while full
    for (int i = 0; i < 8; i++) send_byte(8'h20 + WIDTH'(i), 1);
    check("sim_full", full, 1);
    rx_data = 8'h55;
    rx_rdy  = 1'b1;
    rd_en   = 1'b1;
    exp_q.push_back(8'h55);
    tick();
    rd_en = 1'b0;
    check("sim_count", count, 8);
    check("sim_overflow", overflow, 0);
    check("sim_new_head", rd_data, 8'h21);
    rx_rdy = 1'b0;
    tick();
    pop_n(8);
    check("sim_drained_empty", empty, 1);

    // rd_en while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_count", count, 0);
    check("empty_rd_empty", empty, 1);
    send_byte(8'h3C, 1);
    check("empty_rd_then_push", rd_data, 8'h3C);
    pop_n(1);

    // asynchronous reset mid-run, with rdy high through release
    send_byte(8'h61, 1);
    send_byte(8'h62, 1);
    check("pre_reset_count", count, 2);
    rx_data = 8'h70;
    rx_rdy  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_empty", empty, 1);
    check("async_rst_full", full, 0);
    check("async_rst_count", count, 0);
    check("async_rst_rd_data", rd_data, 0);
    check("async_rst_overflow", overflow, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rdy_through_reset_no_push", count, 0);
    rx_rdy = 1'b0;
    tick();
    send_byte(8'h77, 2);
    check("rearm_capture_count", count, 1);
    check("rearm_capture_data", rd_data, 8'h77);
    pop_n(1);
    check("final_queue_drained", exp_q.size(), 0);
    check("final_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
